// File: rtl/timer_ctrl_if.sv
// Memory-mapped peripheral bus between the CPU data-memory stage and timer_ctrl.
// The CPU owns address, strobes and store data; the peripheral returns read data and decode hit.
interface timer_ctrl_if;
    logic [31:0] addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        hit;

    modport master (
        output addr, mem_read, mem_write, wr_data,
        input  rd_data, hit
    );

    modport slave (
        input  addr, mem_read, mem_write, wr_data,
        output rd_data, hit
    );
endinterface

// File: rtl/timer_ctrl.sv
// Interval timer at BASE_ADDR: TH reload, TL counter, TCON control/status, DBG latch to LEDs.
// TL counts on prescaled ticks, reloads from TH on overflow and sets a sticky interrupt status.
module timer_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic         clk,
    input  logic         reset,
    timer_ctrl_if.slave  bus,
    output logic         irq,
    output logic [7:0]   led
);

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    typedef enum logic [1:0] {
        REG_TH   = 2'd0,
        REG_TL   = 2'd1,
        REG_TCON = 2'd2,
        REG_DBG  = 2'd3
    } reg_sel_e;

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [31:0] dbg;
    logic [15:0] pcnt;

    logic        hit;
    reg_sel_e    sel;
    logic        wr_th, wr_tl, wr_tcon, wr_dbg;
    logic        tick;
    logic        ovf;
    logic        unused_addr_bits;

    assign hit     = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign bus.hit = hit;
    assign sel     = reg_sel_e'(bus.addr[3:2]);

    assign unused_addr_bits = ^bus.addr[1:0];

    assign wr_th   = bus.mem_write && hit && (sel == REG_TH);
    assign wr_tl   = bus.mem_write && hit && (sel == REG_TL);
    assign wr_tcon = bus.mem_write && hit && (sel == REG_TCON);
    assign wr_dbg  = bus.mem_write && hit && (sel == REG_DBG);

    assign tick = tcon[0] && (pcnt == PS_LAST);
    assign ovf  = tick && (tl == 32'hFFFF_FFFF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
        end else if (!tcon[0] || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 16'd1;
        end
    end

    // Software writes take priority over the counter; reload always sees the pre-write TH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
            dbg  <= '0;
        end else begin
            if (wr_th)
                th <= bus.wr_data;

            if (wr_tl)
                tl <= bus.wr_data;
            else if (ovf)
                tl <= th;
            else if (tick)
                tl <= tl + 32'd1;

            if (wr_tcon)
                tcon <= bus.wr_data[2:0];
            else if (ovf && tcon[1])
                tcon[2] <= 1'b1;

            if (wr_dbg)
                dbg <= bus.wr_data;
        end
    end

    always_comb begin
        bus.rd_data = 32'h0;
        if (bus.mem_read && hit) begin
            case (sel)
                REG_TH:   bus.rd_data = th;
                REG_TL:   bus.rd_data = tl;
                REG_TCON: bus.rd_data = {29'h0, tcon};
                default:  bus.rd_data = dbg;
            endcase
        end
    end

    assign irq = tcon[1] & tcon[2];
    assign led = dbg[7:0];

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: two instances (PRESCALE 1 and 4) share one bus stimulus and are
// checked every cycle against a cycle-count reference model, plus directed scenario checks.
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       irq1, irq4;
    logic [7:0] led1, led4;

    timer_ctrl_if b1();
    timer_ctrl_if b4();

    timer_ctrl #(.BASE_ADDR(32'h4000_0000), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .bus(b1.slave), .irq(irq1), .led(led1)
    );
    timer_ctrl #(.BASE_ADDR(32'h4000_0000), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .bus(b4.slave), .irq(irq4), .led(led4)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ecnt = enabled cycles since the timer was last turned on; a tick lands on every ps-th one
    typedef struct {
        logic [31:0] th;
        logic [31:0] tl;
        logic [31:0] dbg;
        logic [2:0]  tcon;
        longint      ecnt;
    } mdl_t;

    localparam mdl_t MZERO = '{th: 32'h0, tl: 32'h0, dbg: 32'h0, tcon: 3'h0, ecnt: 0};

    mdl_t        m1, m4;
    logic [31:0] rd1_s, rd4_s;
    logic        irq1_s, hit_s;

    function automatic logic in_win(logic [31:0] a);
        return a[31:4] == 28'h400_0000;
    endfunction

    function automatic logic [31:0] mread(mdl_t m, logic [31:0] a);
        case (a[3:2])
            2'd0:    return m.th;
            2'd1:    return m.tl;
            2'd2:    return {29'h0, m.tcon};
            default: return m.dbg;
        endcase
    endfunction

    function automatic mdl_t step(mdl_t m, int ps, logic we, logic [31:0] a, logic [31:0] wd);
        mdl_t n;
        logic tk;
        n  = m;
        tk = m.tcon[0] && (((m.ecnt + 1) % ps) == 0);
        n.ecnt = m.tcon[0] ? m.ecnt + 1 : 0;
        if (tk) begin
            if (m.tl == 32'hFFFF_FFFF) begin
                n.tl = m.th;
                if (m.tcon[1]) n.tcon[2] = 1'b1;
            end else begin
                n.tl = m.tl + 32'd1;
            end
        end
        if (we && in_win(a)) begin
            case (a[3:2])
                2'd0:    n.th   = wd;
                2'd1:    n.tl   = wd;
                2'd2:    n.tcon = wd[2:0];
                default: n.dbg  = wd;
            endcase
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic re, input logic we, input logic [31:0] a, input logic [31:0] wd);
        b1.mem_read = re; b1.mem_write = we; b1.addr = a; b1.wr_data = wd;
        b4.mem_read = re; b4.mem_write = we; b4.addr = a; b4.wr_data = wd;
    endtask

    // One bus cycle: drive, sample at the falling edge against the model, then advance the model.
    task automatic cyc(input logic re, input logic we, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] e1, e4;
        drive(re, we, a, wd);
        @(negedge clk);
        if (reset) begin
            m1 = MZERO;
            m4 = MZERO;
        end
        rd1_s  = b1.rd_data;
        rd4_s  = b4.rd_data;
        irq1_s = irq1;
        hit_s  = b1.hit;
        e1 = (re && in_win(a)) ? mread(m1, a) : 32'h0;
        e4 = (re && in_win(a)) ? mread(m4, a) : 32'h0;
        chk("hit1", {31'h0, b1.hit}, {31'h0, in_win(a)});
        chk("hit4", {31'h0, b4.hit}, {31'h0, in_win(a)});
        chk("rd1",  b1.rd_data, e1);
        chk("rd4",  b4.rd_data, e4);
        chk("irq1", {31'h0, irq1}, {31'h0, m1.tcon[1] & m1.tcon[2]});
        chk("irq4", {31'h0, irq4}, {31'h0, m4.tcon[1] & m4.tcon[2]});
        chk("led1", {24'h0, led1}, {24'h0, m1.dbg[7:0]});
        chk("led4", {24'h0, led4}, {24'h0, m4.dbg[7:0]});
        @(posedge clk);
        if (reset) begin
            m1 = MZERO;
            m4 = MZERO;
        end else begin
            m1 = step(m1, 1, we, a, wd);
            m4 = step(m4, 4, we, a, wd);
        end
        #1;
    endtask

    function automatic logic [31:0] ra(input int r);
        return 32'h4000_0000 | (32'(r) << 2);
    endfunction

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h4000_0000, 32'h0);
    endtask

    task automatic wr(input int r, input logic [31:0] d);
        cyc(1'b0, 1'b1, ra(r), d);
    endtask

    task automatic rd(input int r);
        cyc(1'b1, 1'b0, ra(r), 32'h0);
    endtask

    initial begin
        int          ovf_n;
        logic [1:0]  rsel;
        logic [1:0]  op;
        logic [27:0] up;
        logic [31:0] wd;

        m1 = MZERO;
        m4 = MZERO;
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h4000_0000, 32'h0);
        idle();
        idle();
        reset = 1'b0;

        // reset state
        for (int r = 0; r < 4; r++) begin
            rd(r);
            chk("reset_reg", rd1_s, 32'h0);
        end

        // first overflow and reload
        wr(0, 32'hFFFF_3CAF);
        wr(1, 32'hFFFF_FFFF);
        wr(2, 32'h3);
        idle();
        rd(1);
        chk("reload_tl", rd1_s, 32'hFFFF_3CAF);
        chk("ovf_irq", {31'h0, irq1_s}, 32'h1);
        rd(2);
        chk("ovf_tcon", rd1_s, 32'h7);

        // ISR: clear status, log to DBG, re-arm
        wr(2, 32'h7 & 32'hFFF9);
        wr(3, 32'h28);
        chk("isr_irq_low", {31'h0, irq1_s}, 32'h0);
        wr(2, 32'h3);
        chk("isr_led", {24'h0, led1}, 32'h28);

        ovf_n = -1;
        for (int n = 1; n <= 32'hC360; n++) begin
            idle();
            if (irq1 === 1'b1) begin
                ovf_n = n;
                break;
            end
        end
        chk("ovf2_period", 32'(ovf_n + 5), 32'hC351);

        // collision: TCON write in the overflow cycle
        wr(1, 32'hFFFF_FFFF);
        wr(2, 32'h1);
        rd(1);
        chk("coll_tl", rd1_s, 32'hFFFF_3CAF);
        chk("coll_irq", {31'h0, irq1_s}, 32'h0);
        rd(2);
        chk("coll_tcon", rd1_s, 32'h1);

        // prescaler on the PRESCALE=4 instance
        wr(2, 32'h0);
        wr(1, 32'h0);
        wr(2, 32'h1);
        repeat (4) idle();
        rd(1);
        chk("ps4_first", rd4_s, 32'h1);
        repeat (3) idle();
        rd(1);
        chk("ps4_second", rd4_s, 32'h2);
        wr(2, 32'h0);
        repeat (5) idle();
        rd(1);
        chk("ps4_hold", rd4_s, 32'h2);
        chk("ps1_hold", rd1_s, 32'd10);

        // decode
        cyc(1'b0, 1'b1, 32'h4000_0010, 32'hDEAD_BEEF);
        chk("dec_nohit", {31'h0, hit_s}, 32'h0);
        cyc(1'b1, 1'b0, 32'h4000_0010, 32'h0);
        chk("dec_rd0", rd1_s, 32'h0);
        rd(0);
        chk("dec_th_kept", rd1_s, 32'hFFFF_3CAF);
        cyc(1'b0, 1'b1, 32'h4000_0008, 32'hFFFF_FFFF);
        cyc(1'b1, 1'b0, 32'h4000_0009, 32'h0);
        chk("dec_tcon_mask", rd1_s, 32'h7);

        // asynchronous reset while counting with irq high
        chk("pre_rst_irq", {31'h0, irq1}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_irq1", {31'h0, irq1}, 32'h0);
        chk("rst_async_irq4", {31'h0, irq4}, 32'h0);
        chk("rst_async_led", {24'h0, led1}, 32'h0);
        for (int r = 0; r < 4; r++) begin
            drive(1'b1, 1'b0, ra(r), 32'h0);
            #1;
            chk("rst_async_rd1", b1.rd_data, 32'h0);
            chk("rst_async_rd4", b4.rd_data, 32'h0);
        end
        idle();
        reset = 1'b0;

        // randomized traffic, biased toward near-overflow TL values
        for (int i = 0; i < 400; i++) begin
            rsel = 2'($urandom_range(0, 3));
            up   = ($urandom_range(0, 7) == 0) ? 28'h400_0001 : 28'h400_0000;
            wd   = $urandom;
            if (rsel == 2'd1 && $urandom_range(0, 1) == 1)
                wd = 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
            op = 2'($urandom_range(0, 3));
            cyc(op[0], op[1], {up, rsel, 2'($urandom)}, wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
